// File: rtl/regfile_seq_ctrl.sv
// regfile_seq_ctrl
//   Multi-cycle instruction sequencer that drives every port of an 8 x 8-bit
//   RegisterFile (one write port, two combinational read ports). It accepts
//   one 16-bit instruction at a time over a valid/ready handshake. It then
//   reads the operands, runs an 8-bit ALU operation and writes the result back.
//
//   Instruction word: [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2,
//                     [7:0] imm (LOADI only)
//   Ops: 000 LOADI, 001 MOV, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR,
//        111 OUT
//
// Ports:
//   clk, rst_n                    clock / async active-low reset
//   instr, instr_valid            instruction source side
//   instr_ready                   high only while IDLE
//   rf_we, rf_write_addr/data     RegisterFile write port
//   rf_read_addr1/2               RegisterFile read addresses
//   rf_read_data1/2               RegisterFile read data (combinational)
//   out_data, out_valid           value emitted by OUT (one-cycle pulse)
//   zero_flag, carry_flag         flags from the last ADD/SUB/AND/OR/XOR
//   busy, done                    not IDLE / one-cycle retire pulse
//   instr_count                   retired instructions, wraps
module regfile_seq_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic             rf_we,
  output logic [2:0]       rf_write_addr,
  output logic [7:0]       rf_write_data,
  output logic [2:0]       rf_read_addr1,
  output logic [2:0]       rf_read_addr2,
  input  logic [7:0]       rf_read_data1,
  input  logic [7:0]       rf_read_data2,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  typedef enum logic [2:0] {
    OP_LOADI = 3'd0,
    OP_MOV   = 3'd1,
    OP_ADD   = 3'd2,
    OP_SUB   = 3'd3,
    OP_AND   = 3'd4,
    OP_OR    = 3'd5,
    OP_XOR   = 3'd6,
    OP_OUT   = 3'd7
  } op_t;

  state_t     state;
  op_t        op_q;
  logic [2:0] rd_q;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] result_q;
  logic [8:0] alu_res;
  logic       flag_update;

  // rf_we is a pure decode of the state register, so an async reset in WB
  // kills the write strobe in the same timestep and no write can land.
  assign instr_ready   = (state == IDLE);
  assign busy          = (state != IDLE);
  assign rf_we         = (state == WB);
  assign rf_write_addr = rd_q;
  assign rf_write_data = result_q;

  // 9-bit ALU. For SUB, bit 8 of the wrapped difference is the borrow.
  always_comb begin
    alu_res     = {1'b0, op_a};
    flag_update = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_res     = {1'b0, op_a} + {1'b0, op_b};
        flag_update = 1'b1;
      end
      OP_SUB: begin
        alu_res     = {1'b0, op_a} - {1'b0, op_b};
        flag_update = 1'b1;
      end
      OP_AND: begin
        alu_res     = {1'b0, op_a & op_b};
        flag_update = 1'b1;
      end
      OP_OR: begin
        alu_res     = {1'b0, op_a | op_b};
        flag_update = 1'b1;
      end
      OP_XOR: begin
        alu_res     = {1'b0, op_a ^ op_b};
        flag_update = 1'b1;
      end
      default: begin
        alu_res     = {1'b0, op_a};
        flag_update = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= OP_LOADI;
      rd_q          <= 3'd0;
      op_a          <= 8'd0;
      op_b          <= 8'd0;
      result_q      <= 8'd0;
      rf_read_addr1 <= 3'd0;
      rf_read_addr2 <= 3'd0;
      out_data      <= 8'd0;
      out_valid     <= 1'b0;
      zero_flag     <= 1'b0;
      carry_flag    <= 1'b0;
      done          <= 1'b0;
      instr_count   <= '0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q <= op_t'(instr[15:13]);
            rd_q <= instr[12:10];
            if (op_t'(instr[15:13]) == OP_LOADI) begin
              result_q <= instr[7:0];
              state    <= WB;
            end else begin
              // Read addresses are set here so they are stable for all of READ,
              // and they keep this value until the next non-LOADI accept.
              rf_read_addr1 <= instr[9:7];
              rf_read_addr2 <= instr[6:4];
              state         <= READ;
            end
          end
        end
        READ: begin
          op_a  <= rf_read_data1;
          op_b  <= rf_read_data2;
          state <= EXEC;
        end
        EXEC: begin
          if (op_q == OP_OUT) begin
            out_data    <= op_a;
            out_valid   <= 1'b1;
            done        <= 1'b1;
            instr_count <= instr_count + CNT_W'(1);
            state       <= IDLE;
          end else begin
            result_q <= alu_res[7:0];
            if (flag_update) begin
              zero_flag  <= (alu_res[7:0] == 8'd0);
              carry_flag <= alu_res[8];
            end
            state <= WB;
          end
        end
        WB: begin
          done        <= 1'b1;
          instr_count <= instr_count + CNT_W'(1);
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_seq_ctrl.sv
// tb_regfile_seq_ctrl
//   Drives regfile_seq_ctrl against a behavioural 8 x 8-bit register file. A
//   reference model predicts register writes, OUT values, flags, latency and
//   retire count when each instruction is issued. Writes and OUT values are
//   queued and then checked as the DUT produces them. A narrow counter is used
//   so the retire count wraps during the run.
module tb_regfile_seq_ctrl;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic [15:0]      instr;
  logic             instr_valid;
  logic             instr_ready;
  logic             rf_we;
  logic [2:0]       rf_write_addr;
  logic [7:0]       rf_write_data;
  logic [2:0]       rf_read_addr1;
  logic [2:0]       rf_read_addr2;
  logic [7:0]       rf_read_data1;
  logic [7:0]       rf_read_data2;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             zero_flag;
  logic             carry_flag;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] instr_count;

  regfile_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .rf_we         (rf_we),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rf_read_addr1 (rf_read_addr1),
    .rf_read_addr2 (rf_read_addr2),
    .rf_read_data1 (rf_read_data1),
    .rf_read_data2 (rf_read_data2),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .busy          (busy),
    .done          (done),
    .instr_count   (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RegisterFile: combinational reads, write on posedge when we.
  logic [7:0] rf_mem [8];
  initial for (int i = 0; i < 8; i++) rf_mem[i] = 8'd0;
  always @(posedge clk) if (rf_we) rf_mem[rf_write_addr] <= rf_write_data;
  assign rf_read_data1 = rf_mem[rf_read_addr1];
  assign rf_read_data2 = rf_mem[rf_read_addr2];

  int checks = 0;
  int errors = 0;

  logic [10:0] wr_q [$];
  logic [7:0]  out_q [$];
  logic [7:0]  model_rf [8];
  logic        model_zero;
  logic        model_carry;
  int          exp_count;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] loadi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b000, rd, 2'b00, imm};
  endfunction

  // Reference model: updates architectural state, queues expected effects and
  // returns the accept-to-done latency.
  function automatic int predict(input logic [15:0] ins);
    logic [2:0] op, rd, rs1, rs2;
    logic [7:0] a, b, r;
    logic       c;
    op  = ins[15:13];
    rd  = ins[12:10];
    rs1 = ins[9:7];
    rs2 = ins[6:4];
    a   = model_rf[rs1];
    b   = model_rf[rs2];
    c   = 1'b0;
    r   = 8'd0;
    exp_count++;
    if (op == 3'd0) begin
      model_rf[rd] = ins[7:0];
      wr_q.push_back({rd, ins[7:0]});
      return 2;
    end
    if (op == 3'd7) begin
      out_q.push_back(a);
      return 3;
    end
    case (op)
      3'd1: r = a;
      3'd2: begin r = a + b; c = (int'(a) + int'(b)) > 255; end
      3'd3: begin r = a - b; c = (a < b); end
      3'd4: r = a & b;
      3'd5: r = a | b;
      default: r = a ^ b;
    endcase
    if (op != 3'd1) begin
      model_zero  = (r == 8'd0);
      model_carry = c;
    end
    model_rf[rd] = r;
    wr_q.push_back({rd, r});
    return 4;
  endfunction

  // Scoreboard consumer: every write strobe and OUT pulse must match the head
  // of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_we) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write addr %0d data %h, none expected", rf_write_addr, rf_write_data);
        end else begin
          logic [10:0] exp;
          exp = wr_q.pop_front();
          if ({rf_write_addr, rf_write_data} !== exp) begin
            errors++;
            $display("[TB] FAIL write got addr %0d data %h want addr %0d data %h",
                     rf_write_addr, rf_write_data, exp[10:8], exp[7:0]);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (out_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_out data %h, none expected", out_data);
        end else begin
          logic [7:0] exp;
          exp = out_q.pop_front();
          if (out_data !== exp) begin
            errors++;
            $display("[TB] FAIL out_data got %h want %h", out_data, exp);
          end
        end
      end
    end
  end

  // Called at posedge+1 after the accept edge (or later, with 'already' cycles
  // consumed). Returns at posedge+1 one cycle after done was seen.
  task automatic wait_done(input int exp_lat, input int already, input string name);
    int  lat;
    bit  seen;
    lat  = 1 + already;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    checks++;
    if (!seen || lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL latency_%s got %0d (seen %0d) want %0d", name, lat, seen, exp_lat);
    end
    checks++;
    if (instr_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("[TB] FAIL count_%s got %0d want %0d", name, instr_count, CNT_W'(exp_count));
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse_%s got %b want 0", name, done);
    end
  endtask

  task automatic issue(input logic [15:0] ins, input string name);
    int n;
    int lat;
    n = 0;
    while (instr_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout_%s got 0 want 1", name);
    end
    instr       = ins;
    instr_valid = 1'b1;
    lat = predict(ins);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    wait_done(lat, 0, name);
  endtask

  task automatic test_reset();
    int lat;
    rst_n       = 1'b0;
    instr       = loadi(3'd0, 8'h55);
    instr_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rf_we, out_valid, done, busy, zero_flag, carry_flag} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got we/ov/done/busy/z/c %b want 000000",
               {rf_we, out_valid, done, busy, zero_flag, carry_flag});
    end
    checks++;
    if (out_data !== 8'd0 || instr_count !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data got out_data %h count %0d want 00 0", out_data, instr_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (instr_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ready_after_reset got %b want 1", instr_ready);
    end
    lat = predict(instr);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_after_reset busy got %b want 1", busy);
    end
    wait_done(lat, 0, "loadi_r0");
  endtask

  task automatic test_loadi_out();
    issue(loadi(3'd1, 8'hAA), "loadi_r1");
    issue(enc(3'd7, 3'd0, 3'd0, 3'd0), "out_r0");
    issue(enc(3'd7, 3'd0, 3'd1, 3'd0), "out_r1");
    checks++;
    if (instr_count !== CNT_W'(4)) begin
      errors++;
      $display("[TB] FAIL count_after_four got %0d want 4", instr_count);
    end
  endtask

  task automatic test_add();
    issue(loadi(3'd2, 8'hF0), "loadi_r2");
    issue(loadi(3'd3, 8'h20), "loadi_r3");
    issue(enc(3'd2, 3'd4, 3'd2, 3'd3), "add_r4");
    checks++;
    if (rf_mem[4] !== 8'h10 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_r4 got r4 %h c %b z %b want 10 1 0", rf_mem[4], carry_flag, zero_flag);
    end
  endtask

  task automatic test_sub();
    issue(loadi(3'd5, 8'h10), "loadi_r5");
    issue(enc(3'd3, 3'd6, 3'd5, 3'd5), "sub_r6");
    checks++;
    if (rf_mem[6] !== 8'h00 || zero_flag !== 1'b1 || carry_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_r6 got r6 %h z %b c %b want 00 1 0", rf_mem[6], zero_flag, carry_flag);
    end
    issue(enc(3'd3, 3'd7, 3'd3, 3'd2), "sub_r7");
    checks++;
    if (rf_mem[7] !== 8'h30 || carry_flag !== 1'b1 || zero_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sub_r7 got r7 %h c %b z %b want 30 1 0", rf_mem[7], carry_flag, zero_flag);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [7:0] old_r2;
    old_r2      = model_rf[2];
    instr       = loadi(3'd1, 8'h0F);
    instr_valid = 1'b1;
    lat = predict(instr);
    @(posedge clk);
    #1;
    instr = loadi(3'd2, 8'h77);
    checks++;
    if (instr_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_ready_wb got %b want 0", instr_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || instr_ready !== 1'b1 || instr_count !== CNT_W'(exp_count)) begin
      errors++;
      $display("[TB] FAIL b2b_loadi_retire got done %b ready %b count %0d want 1 1 %0d",
               done, instr_ready, instr_count, CNT_W'(exp_count));
    end
    instr = enc(3'd6, 3'd1, 3'd1, 3'd1);
    lat = predict(instr);
    @(posedge clk);
    #1;
    instr = loadi(3'd2, 8'h77);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (instr_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL b2b_ready_busy%0d got %b want 0", i, instr_ready);
      end
    end
    instr_valid = 1'b0;
    wait_done(lat, 2, "xor_r1");
    checks++;
    if (rf_mem[1] !== 8'h00 || zero_flag !== 1'b1 || rf_mem[2] !== old_r2) begin
      errors++;
      $display("[TB] FAIL b2b_result got r1 %h z %b r2 %h want 00 1 %h", rf_mem[1], zero_flag, rf_mem[2], old_r2);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      issue(16'($urandom), "random");
    end
    for (int r = 0; r < 8; r++) begin
      checks++;
      if (rf_mem[r] !== model_rf[r]) begin
        errors++;
        $display("[TB] FAIL random_r%0d got %h want %h", r, rf_mem[r], model_rf[r]);
      end
    end
    checks++;
    if (zero_flag !== model_zero || carry_flag !== model_carry) begin
      errors++;
      $display("[TB] FAIL random_flags got z %b c %b want z %b c %b", zero_flag, carry_flag, model_zero, model_carry);
    end
  endtask

  task automatic test_reset_mid_wb();
    logic [7:0] old_r4;
    old_r4      = model_rf[4];
    instr       = enc(3'd2, 3'd4, 3'd2, 3'd3);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (rf_we !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_wb_we got %b want 1", rf_we);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 1'b0 || instr_count !== '0 || zero_flag !== 1'b0 || carry_flag !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_wb_reset got we %b busy %b count %0d z %b c %b want 0 0 0 0 0",
               rf_we, busy, instr_count, zero_flag, carry_flag);
    end
    @(posedge clk);
    #1;
    checks++;
    if (rf_mem[4] !== old_r4) begin
      errors++;
      $display("[TB] FAIL mid_wb_r4 got %h want %h", rf_mem[4], old_r4);
    end
    exp_count   = 0;
    model_zero  = 1'b0;
    model_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(loadi(3'd0, 8'h3C), "after_reset");
    checks++;
    if (rf_mem[0] !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL after_reset_r0 got %h want 3c", rf_mem[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model_rf[i] = 8'd0;
    model_zero  = 1'b0;
    model_carry = 1'b0;
    exp_count   = 0;
    rst_n       = 1'b0;
    instr       = 16'd0;
    instr_valid = 1'b0;
    test_reset();
    test_loadi_out();
    test_add();
    test_sub();
    test_back_to_back();
    test_random();
    test_reset_mid_wb();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wr_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL queues_drained got wr %0d out %0d want 0 0", wr_q.size(), out_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
